// File: rtl/snn_pkg.sv
// Shared constants, bus payload and FSM encoding for the SNN accelerator Wishbone host.
package snn_pkg;

  localparam int unsigned NUM_PIXELS   = 196;
  localparam int unsigned HALF_WEIGHTS = 980;
  localparam int unsigned OUTPUTS      = 10;

  localparam logic [31:0] IMG_OFS  = 32'h0000_0000;
  localparam logic [31:0] W0_OFS   = 32'h0000_1000;
  localparam logic [31:0] W1_OFS   = 32'h0000_2000;
  localparam logic [31:0] OUT_OFS  = 32'h0000_3000;
  localparam logic [31:0] CTRL_OFS = 32'h0000_4000;

  localparam int unsigned CTRL_EN_BIT   = 29;
  localparam int unsigned CTRL_DONE_BIT = 30;
  localparam int unsigned CTRL_TS_LSB   = 16;
  localparam int unsigned CTRL_VTH_LSB  = 8;
  localparam int unsigned CTRL_BETA_LSB = 0;

  localparam int unsigned TS_W   = 10;
  localparam int unsigned VTH_W  = 8;
  localparam int unsigned BETA_W = 8;
  localparam int unsigned CNT_W  = 10;

  typedef enum logic [3:0] {
    ST_IDLE, ST_LD_IMG, ST_LD_W0, ST_LD_W1, ST_WR_CTRL,
    ST_POLL, ST_RD_OUT, ST_FINISH, ST_ERR
  } state_e;

  typedef struct packed {
    logic [TS_W-1:0]   ts;
    logic [VTH_W-1:0]  vth;
    logic [BETA_W-1:0] beta;
  } cfg_t;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_req_t;

  function automatic logic is_load(input state_e s);
    return s inside {ST_LD_IMG, ST_LD_W0, ST_LD_W1};
  endfunction

  // Word-indexed address inside one region of the accelerator map.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] ofs,
                                            input logic [CNT_W-1:0] idx);
    return base + ofs + {20'b0, idx, 2'b00};
  endfunction

  function automatic logic [31:0] ctrl_word(input cfg_t c);
    logic [31:0] w;
    w = '0;
    w[CTRL_EN_BIT] = 1'b1;
    w[CTRL_TS_LSB +: TS_W] = c.ts;
    w[CTRL_VTH_LSB +: VTH_W] = c.vth;
    w[CTRL_BETA_LSB +: BETA_W] = c.beta;
    return w;
  endfunction

endpackage

// File: rtl/snn_wb_host_xfer.sv
// One-transaction Wishbone classic master with an ack timeout.
module wb_single_xfer
  import snn_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_c,
  input  wb_req_t     req_i,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic        ack_c,
  output logic        timeout_c,
  output logic [31:0] rdata_c
);

  localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  logic             cyc_q, cyc_d;
  logic             we_q, we_d;
  logic [31:0]      adr_q, adr_d;
  logic [31:0]      dat_q, dat_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Acks outside an open cycle are ignored; the cycle closes on ack or timeout.
  always_comb begin
    cyc_d     = cyc_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    tmo_d     = tmo_q;
    ack_c     = cyc_q & wbm_ack_i;
    timeout_c = cyc_q & ~wbm_ack_i & (tmo_q == TMO_LAST);
    rdata_c   = wbm_dat_i;
    if (cyc_q) begin
      if (ack_c || timeout_c) begin
        cyc_d = 1'b0;
        we_d  = 1'b0;
        tmo_d = '0;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end else if (req_c) begin
      cyc_d = 1'b1;
      we_d  = req_i.we;
      adr_d = req_i.adr;
      dat_d = req_i.dat;
      tmo_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_q <= 1'b0;
      we_q  <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
      tmo_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      we_q  <= we_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
      tmo_q <= tmo_d;
    end
  end

  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = {4{cyc_q}};
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;

endmodule

// File: rtl/snn_wb_host.sv
// Wishbone host that loads image/weights into the SNN accelerator, starts it and reads results.
module snn_wb_host
  import snn_pkg::*;
#(
  parameter logic [31:0] BASE        = 32'h3000_0000,
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned POLL_LIMIT  = 65535
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              start_i,
  input  logic              load_i,
  input  logic [TS_W-1:0]   cfg_timesteps_i,
  input  logic [VTH_W-1:0]  cfg_vth_i,
  input  logic [BETA_W-1:0] cfg_beta_i,
  input  logic              data_valid_i,
  input  logic [7:0]        data_i,
  output logic              data_ready_o,
  output logic              res_valid_o,
  output logic [3:0]        res_idx_o,
  output logic [7:0]        res_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [3:0]        wbm_sel_o,
  output logic [31:0]       wbm_adr_o,
  output logic [31:0]       wbm_dat_o,
  input  logic              wbm_ack_i,
  input  logic [31:0]       wbm_dat_i
);

  localparam int unsigned POLL_W = $clog2(POLL_LIMIT + 1);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_LIMIT - 1);
  localparam logic [CNT_W-1:0]  IMG_LAST  = CNT_W'(NUM_PIXELS - 1);
  localparam logic [CNT_W-1:0]  W_LAST    = CNT_W'(HALF_WEIGHTS - 1);
  localparam logic [CNT_W-1:0]  OUT_LAST  = CNT_W'(OUTPUTS - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [POLL_W-1:0] poll_q, poll_d;
  cfg_t              cfg_q, cfg_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;
  logic              res_valid_q, res_valid_d;
  logic [3:0]        res_idx_q, res_idx_d;
  logic [7:0]        res_data_q, res_data_d;

  wb_req_t           req;
  logic              req_c, ack_c, timeout_c, open_c, accept_c;
  logic [31:0]       rdata_c;
  logic [31:0]       ld_ofs;
  logic [CNT_W-1:0]  ld_last;
  state_e            ld_next;
  logic              unused_rdata;

  assign unused_rdata = ^{rdata_c[31], rdata_c[29:8]};

  // Region, last index and successor for the current load state.
  always_comb begin
    ld_ofs  = IMG_OFS;
    ld_last = IMG_LAST;
    ld_next = ST_LD_W0;
    case (state_q)
      ST_LD_W0: begin
        ld_ofs  = W0_OFS;
        ld_last = W_LAST;
        ld_next = ST_LD_W1;
      end
      ST_LD_W1: begin
        ld_ofs  = W1_OFS;
        ld_last = W_LAST;
        ld_next = ST_WR_CTRL;
      end
      default: ;
    endcase
  end

  assign accept_c = is_load(state_q) & data_valid_i & ready_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    poll_d      = poll_q;
    cfg_d       = cfg_q;
    busy_d      = busy_q;
    err_d       = err_q;
    done_d      = 1'b0;
    res_valid_d = 1'b0;
    res_idx_d   = res_idx_q;
    res_data_d  = res_data_q;
    req_c       = 1'b0;
    req         = '0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          cfg_d   = '{ts: cfg_timesteps_i, vth: cfg_vth_i, beta: cfg_beta_i};
          err_d   = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          poll_d  = '0;
          state_d = load_i ? ST_LD_IMG : ST_WR_CTRL;
        end
      end
      ST_LD_IMG, ST_LD_W0, ST_LD_W1: begin
        req_c   = accept_c;
        req.we  = 1'b1;
        req.adr = word_addr(BASE, ld_ofs, cnt_q);
        req.dat = {24'b0, data_i};
        if (ack_c) begin
          if (cnt_q == ld_last) begin
            cnt_d   = '0;
            state_d = ld_next;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_WR_CTRL: begin
        req_c   = ~wbm_cyc_o;
        req.we  = 1'b1;
        req.adr = BASE + CTRL_OFS;
        req.dat = ctrl_word(cfg_q);
        if (ack_c) begin
          poll_d  = '0;
          state_d = ST_POLL;
        end
      end
      ST_POLL: begin
        // Issuing only while the bus is closed leaves one idle cycle between reads.
        req_c   = ~wbm_cyc_o;
        req.adr = BASE + CTRL_OFS;
        if (ack_c) begin
          if (rdata_c[CTRL_DONE_BIT]) begin
            cnt_d   = '0;
            state_d = ST_RD_OUT;
          end else if (poll_q == POLL_LAST) begin
            state_d = ST_ERR;
          end else begin
            poll_d = poll_q + POLL_W'(1);
          end
        end
      end
      ST_RD_OUT: begin
        req_c   = ~wbm_cyc_o;
        req.adr = word_addr(BASE, OUT_OFS, cnt_q);
        if (ack_c) begin
          res_valid_d = 1'b1;
          res_idx_d   = 4'(cnt_q);
          res_data_d  = rdata_c[7:0];
          if (cnt_q == OUT_LAST) begin
            state_d = ST_FINISH;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        err_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (timeout_c) begin
      state_d = ST_ERR;
    end
  end

  // A bus cycle is open next cycle if one starts now or the current one continues.
  assign open_c  = req_c | (wbm_cyc_o & ~ack_c & ~timeout_c);
  assign ready_d = is_load(state_d) & ~open_c;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      poll_q      <= '0;
      cfg_q       <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_idx_q   <= '0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      poll_q      <= poll_d;
      cfg_q       <= cfg_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      done_q      <= done_d;
      ready_q     <= ready_d;
      res_valid_q <= res_valid_d;
      res_idx_q   <= res_idx_d;
      res_data_q  <= res_data_d;
    end
  end

  wb_single_xfer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_xfer (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_ni),
    .req_c     (req_c),
    .req_i     (req),
    .wbm_ack_i (wbm_ack_i),
    .wbm_dat_i (wbm_dat_i),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .ack_c     (ack_c),
    .timeout_c (timeout_c),
    .rdata_c   (rdata_c)
  );

  assign data_ready_o = ready_q;
  assign res_valid_o  = res_valid_q;
  assign res_idx_o    = res_idx_q;
  assign res_data_o   = res_data_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_snn_wb_host.sv
// Directed bench for snn_wb_host with a Wishbone slave model and bus-rule monitor.
module tb_snn_wb_host;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        load_i = 1'b0;
  logic [9:0]  cfg_timesteps_i = '0;
  logic [7:0]  cfg_vth_i = '0;
  logic [7:0]  cfg_beta_i = '0;
  logic        data_valid_i = 1'b0;
  logic [7:0]  data_i = '0;
  logic        data_ready_o, res_valid_o, busy_o, done_o, err_o;
  logic [3:0]  res_idx_o;
  logic [7:0]  res_data_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;

  always #5 clk = ~clk;

  snn_wb_host dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start_i), .load_i(load_i),
    .cfg_timesteps_i(cfg_timesteps_i), .cfg_vth_i(cfg_vth_i), .cfg_beta_i(cfg_beta_i),
    .data_valid_i(data_valid_i), .data_i(data_i), .data_ready_o(data_ready_o),
    .res_valid_o(res_valid_o), .res_idx_o(res_idx_o), .res_data_o(res_data_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
  );

  // Slave model controls
  bit          rnd_wait = 1'b0;
  int          fixed_wait = 0;
  bit          hang_en = 1'b0;
  logic [31:0] hang_adr = '0;
  int          done_on = 1;
  int          ctrl_base = 0;

  int          s_wcnt = 0;
  int          s_tgt = 0;
  int          n_wr = 0, n_rd = 0, n_ctrl_rd = 0;
  logic [31:0] wlog_adr [0:8191];
  logic [31:0] wlog_dat [0:8191];
  logic [31:0] rlog_adr [0:1023];
  logic        s_hang;

  assign s_hang    = hang_en && wbm_we_o && (wbm_adr_o == hang_adr);
  assign wbm_ack_i = wbm_cyc_o && wbm_stb_o && (s_wcnt >= s_tgt) && !s_hang;

  always_comb begin
    wbm_dat_i = 32'h0;
    if (wbm_adr_o == 32'h3000_4000) begin
      wbm_dat_i = 32'h2000_0000;
      wbm_dat_i[30] = ((n_ctrl_rd - ctrl_base + 1) >= done_on);
    end else if (wbm_adr_o[31:12] == 20'h30003) begin
      wbm_dat_i = {8'hA5, 16'h0, 8'h50 + wbm_adr_o[9:2]};
    end
  end

  always @(posedge clk) begin
    if (wbm_cyc_o && wbm_stb_o) begin
      if (wbm_ack_i) begin
        s_wcnt <= 0;
        s_tgt  <= rnd_wait ? int'($urandom_range(5, 1)) : fixed_wait;
        if (wbm_we_o) begin
          if (n_wr < 8192) begin
            wlog_adr[n_wr] <= wbm_adr_o;
            wlog_dat[n_wr] <= wbm_dat_o;
          end
          n_wr <= n_wr + 1;
        end else begin
          if (n_rd < 1024) rlog_adr[n_rd] <= wbm_adr_o;
          n_rd <= n_rd + 1;
          if (wbm_adr_o == 32'h3000_4000) n_ctrl_rd <= n_ctrl_rd + 1;
        end
      end else begin
        s_wcnt <= s_wcnt + 1;
      end
    end else begin
      s_wcnt <= 0;
    end
  end

  // Bus-rule monitor and result capture
  int          viol_stb = 0, viol_stable = 0, viol_rdy = 0, viol_sel = 0;
  int          res_n = 0, done_n = 0;
  logic [3:0]  res_idx_log [0:255];
  logic [7:0]  res_dat_log [0:255];
  bit          prev_wait = 1'b0;
  logic [31:0] prev_adr = '0, prev_dat = '0;
  logic        prev_we = 1'b0;

  always @(posedge clk) begin
    if (wbm_stb_o !== wbm_cyc_o) viol_stb <= viol_stb + 1;
    if (data_ready_o && wbm_cyc_o) viol_rdy <= viol_rdy + 1;
    if (wbm_cyc_o && wbm_sel_o !== 4'hF) viol_sel <= viol_sel + 1;
    if (prev_wait && wbm_cyc_o &&
        (wbm_adr_o !== prev_adr || wbm_dat_o !== prev_dat || wbm_we_o !== prev_we))
      viol_stable <= viol_stable + 1;
    prev_wait <= wbm_cyc_o && !wbm_ack_i && rst_n;
    prev_adr  <= wbm_adr_o;
    prev_dat  <= wbm_dat_o;
    prev_we   <= wbm_we_o;
    if (res_valid_o) begin
      if (res_n < 256) begin
        res_idx_log[res_n] <= res_idx_o;
        res_dat_log[res_n] <= res_data_o;
      end
      res_n <= res_n + 1;
    end
    if (done_o) done_n <= done_n + 1;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int k);
    return 8'(k * 7 + 1);
  endfunction

  function automatic logic [31:0] exp_adr(input int k);
    if (k < 196) return 32'h3000_0000 + 32'(4 * k);
    else if (k < 1176) return 32'h3000_1000 + 32'(4 * (k - 196));
    else return 32'h3000_2000 + 32'(4 * (k - 1176));
  endfunction

  task automatic do_start(input bit ld, input logic [9:0] ts, input logic [7:0] vth,
                          input logic [7:0] beta);
    @(negedge clk);
    start_i = 1'b1;
    load_i = ld;
    cfg_timesteps_i = ts;
    cfg_vth_i = vth;
    cfg_beta_i = beta;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Returns at the negedge after the last byte's accepting edge.
  task automatic stream(input int n, input bit rnd, output bit ok);
    int k = 0;
    int guard = 0;
    bit will_accept;
    @(negedge clk);
    while (k < n && guard < 40000) begin
      data_i = pat(k);
      data_valid_i = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
      will_accept = data_valid_i && data_ready_o;
      @(negedge clk);
      if (will_accept) k++;
      guard++;
    end
    data_valid_i = 1'b0;
    ok = (k == n);
  endtask

  task automatic wait_done(input int base, input int budget, output bit ok);
    int t = 0;
    while (done_n == base && t < budget) begin
      @(negedge clk);
      t++;
    end
    ok = (done_n != base);
  endtask

  int wb0, rb0, resb, db, errs, open_cyc;
  bit ok;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_cyc", 32'(wbm_cyc_o), 0);
    check("rst_adr", wbm_adr_o, 0);
    check("rst_dat", wbm_dat_o, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", 32'(data_ready_o), 0);
    check("idle_flags", 32'({err_o, done_o, res_valid_o, wbm_stb_o}), 0);

    // Full load, zero-wait slave; busy start and cfg change must be ignored
    done_on = 1;
    wb0 = n_wr; rb0 = n_rd; resb = res_n; db = done_n;
    do_start(1'b1, 10'd100, 8'h10, 8'h05);
    check("a_busy", 32'(busy_o), 1);
    check("a_ready", 32'(data_ready_o), 1);
    do_start(1'b0, 10'd3, 8'hFF, 8'hFF);
    stream(2156, 1'b0, ok);
    check("a_stream_done", 32'(ok), 1);
    wait_done(db, 3000, ok);
    check("a_done_seen", 32'(ok), 1);
    repeat (4) @(negedge clk);
    check("a_done_once", 32'(done_n - db), 1);
    check("a_busy_end", 32'(busy_o), 0);
    check("a_nwrites", 32'(n_wr - wb0), 2157);
    check("a_last_img", wlog_adr[wb0 + 195], 32'h3000_030C);
    check("a_first_w0", wlog_adr[wb0 + 196], 32'h3000_1000);
    check("a_last_w1", wlog_adr[wb0 + 2155], 32'h3000_2F4C);
    check("a_ctrl_adr", wlog_adr[wb0 + 2156], 32'h3000_4000);
    check("a_ctrl_dat", wlog_dat[wb0 + 2156], 32'h2064_1005);
    errs = 0;
    for (int k = 0; k < 2156; k++)
      if (wlog_adr[wb0 + k] !== exp_adr(k) || wlog_dat[wb0 + k] !== {24'h0, pat(k)}) errs++;
    check("a_stream_words", 32'(errs), 0);
    check("a_nreads", 32'(n_rd - rb0), 11);
    check("a_nres", 32'(res_n - resb), 10);

    // Timeout: third image write never acked
    hang_en = 1'b1;
    hang_adr = 32'h3000_0008;
    do_start(1'b1, 10'd100, 8'h10, 8'h05);
    stream(3, 1'b0, ok);
    check("d_stream", 32'(ok), 1);
    check("d_cyc_open", 32'(wbm_cyc_o), 1);
    check("d_hang_adr", wbm_adr_o, 32'h3000_0008);
    open_cyc = 0;
    while (wbm_cyc_o && open_cyc < 400) begin
      open_cyc++;
      @(negedge clk);
    end
    check("d_open_cycles", 32'(open_cyc), 255);
    @(negedge clk);
    check("d_err", 32'(err_o), 1);
    check("d_busy", 32'(busy_o), 0);
    check("d_cyc_low", 32'(wbm_cyc_o), 0);
    hang_en = 1'b0;
    repeat (3) @(negedge clk);
    check("d_err_sticky", 32'(err_o), 1);

    // No load; done on third poll; start clears err
    done_on = 3;
    ctrl_base = n_ctrl_rd;
    wb0 = n_wr; rb0 = n_rd; resb = res_n; db = done_n;
    do_start(1'b0, 10'd7, 8'h22, 8'h33);
    check("b_err_cleared", 32'(err_o), 0);
    check("b_busy", 32'(busy_o), 1);
    check("b_ready", 32'(data_ready_o), 0);
    wait_done(db, 500, ok);
    check("b_done_seen", 32'(ok), 1);
    repeat (4) @(negedge clk);
    check("b_done_once", 32'(done_n - db), 1);
    check("b_nwrites", 32'(n_wr - wb0), 1);
    check("b_ctrl_dat", wlog_dat[wb0], 32'h2007_2233);
    check("b_polls", 32'(n_ctrl_rd - ctrl_base), 3);
    check("b_nreads", 32'(n_rd - rb0), 13);
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      if (rlog_adr[rb0 + 3 + i] !== 32'h3000_3000 + 32'(4 * i)) errs++;
      if (res_idx_log[resb + i] !== 4'(i)) errs++;
      if (res_dat_log[resb + i] !== 8'h50 + 8'(i)) errs++;
    end
    check("b_outputs", 32'(errs), 0);
    check("b_nres", 32'(res_n - resb), 10);

    // Random slave waits and random valid
    rnd_wait = 1'b1;
    done_on = 1;
    wb0 = n_wr; db = done_n;
    do_start(1'b1, 10'd100, 8'h10, 8'h05);
    stream(2156, 1'b1, ok);
    check("c_stream_done", 32'(ok), 1);
    wait_done(db, 3000, ok);
    check("c_done_seen", 32'(ok), 1);
    check("c_nwrites", 32'(n_wr - wb0), 2157);
    errs = 0;
    for (int k = 0; k < 2156; k++)
      if (wlog_adr[wb0 + k] !== exp_adr(k) || wlog_dat[wb0 + k] !== {24'h0, pat(k)}) errs++;
    check("c_stream_words", 32'(errs), 0);
    check("c_ctrl_dat", wlog_dat[wb0 + 2156], 32'h2064_1005);

    // Reset during a weight-bank-0 write, then restart
    rnd_wait = 1'b0;
    fixed_wait = 3;
    do_start(1'b1, 10'd100, 8'h10, 8'h05);
    stream(201, 1'b0, ok);
    check("e_stream", 32'(ok), 1);
    check("e_cyc_open", 32'(wbm_cyc_o), 1);
    check("e_w0_adr", wbm_adr_o, 32'h3000_1010);
    check("e_w0_dat", wbm_dat_o, {24'h0, pat(200)});
    rst_n = 1'b0;
    @(negedge clk);
    check("e_rst_cyc_stb", 32'({wbm_cyc_o, wbm_stb_o}), 0);
    check("e_rst_busy", 32'(busy_o), 0);
    rst_n = 1'b1;
    @(negedge clk);
    wb0 = n_wr;
    do_start(1'b1, 10'd100, 8'h10, 8'h05);
    stream(1, 1'b0, ok);
    check("e_restart_cyc", 32'(wbm_cyc_o), 1);
    check("e_restart_adr", wbm_adr_o, 32'h3000_0000);
    repeat (8) @(negedge clk);
    check("e_restart_write", 32'(n_wr - wb0), 1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("bus_stb_eq_cyc", 32'(viol_stb), 0);
    check("bus_stable", 32'(viol_stable), 0);
    check("bus_ready_closed", 32'(viol_rdy), 0);
    check("bus_sel", 32'(viol_sel), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
